axi_lite_sram_slave: RTL and testbench

AXI4-Lite responder modelling on-chip SRAM behind the LSU/IFU masters. It is the slave end of the read/write channels those masters drive. Read and write paths are independent, each with its own FSM and programmable response latency. It holds a word-organised memory array with byte-strobe writes, and decodes address range and size into AXI response codes.

---
 rtl/axi_lite_pkg.sv | 26 ++
 rtl/axi_lite_sram_slave_if.sv | 32 +++
 rtl/axi_lite_lfsr8.sv | 18 +
 rtl/axi_lite_sram_slave.sv | 203 ++++++++++++++++++++
 tb/tb_axi_lite_sram_slave.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response/size codes, FSM state types and address decode for the SRAM slave.
// Combinational only: no latency and no flow control of its own.
package axi_lite_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_SIZE_B = 3'b000;
  localparam logic [2:0] AXI_SIZE_H = 3'b001;
  localparam logic [2:0] AXI_SIZE_W = 3'b010;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  // An out-of-range address outranks an oversize access.
  function automatic logic [1:0] axi_decode(input logic [31:0] addr, input logic [2:0] size,
                                            input logic [31:0] base, input logic [31:0] span);
    logic [31:0] off;
    off = addr - base;
    if ((addr < base) || (off >= span)) return AXI_RESP_DECERR;
    if (size > AXI_SIZE_W) return AXI_RESP_SLVERR;
    return AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_lite_sram_slave_if.sv
// AXI4-Lite AR/R/AW/W/B channel bundle between the LSU/IFU masters and the SRAM slave.
// Wires only: no latency; each channel uses valid/ready backpressure.
interface axi_lite_sram_slave_if;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arsize, arvalid, rready, awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
  modport slave (
    input  araddr, arsize, arvalid, rready, awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded with 8'hA5 on reset; advances every clock.
// Free-running: no handshake and no backpressure.
module axi_lite_lfsr8 (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] state
);
  logic [7:0] state_q, state_d;

  always_comb state_d = {state_q[6:0], state_q[7] ^ state_q[5] ^ state_q[4] ^ state_q[3]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= 8'hA5;
    else     state_q <= state_d;
  end

  assign state = state_q;
endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite SRAM slave: R at 1+READ_LAT after AR, B at 1+WRITE_LAT after the later of AW/W; ready drops while busy.
// AXI_SLAVE_RAND_LAT_EN adds LFSR-driven random extra latency; R/B hold stable until rready/bready.
module axi_lite_sram_slave
  import axi_lite_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0f000000,
  parameter int          MEM_WORDS = 1024,
  parameter int          READ_LAT  = 1,
  parameter int          WRITE_LAT = 1
) (
  input logic                  clk,
  input logic                  rst,
  axi_lite_sram_slave_if.slave s_axi
);
  localparam int          IDX_W = $clog2(MEM_WORDS);
  localparam logic [31:0] SPAN  = 32'(MEM_WORDS) << 2;

  logic [31:0] mem [MEM_WORDS];

  r_state_t         r_state_q, r_state_d;
  logic [4:0]       r_cnt_q, r_cnt_d, r_load;
  logic [IDX_W-1:0] r_idx_q, r_idx_d;
  logic [1:0]       r_err_q, r_err_d;
  logic             arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [1:0]       rresp_q, rresp_d;

  w_state_t         w_state_q, w_state_d;
  logic [4:0]       w_cnt_q, w_cnt_d, w_load;
  logic [IDX_W-1:0] w_idx_q, w_idx_d;
  logic [1:0]       w_err_q, w_err_d;
  logic [31:0]      w_data_q, w_data_d;
  logic [3:0]       w_strb_q, w_strb_d;
  logic             aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic             awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d;
  logic             aw_fire, w_fire, w_commit;

`ifdef AXI_SLAVE_RAND_LAT_EN
  logic [7:0] lfsr_state;
  axi_lite_lfsr8 u_lfsr (.clk(clk), .rst(rst), .state(lfsr_state));
  assign r_load = 5'(READ_LAT) + {3'b000, lfsr_state[1:0]};
  assign w_load = 5'(WRITE_LAT) + {3'b000, lfsr_state[3:2]};
`else
  assign r_load = 5'(READ_LAT);
  assign w_load = 5'(WRITE_LAT);
`endif

  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    r_idx_d   = r_idx_q;
    r_err_d   = r_err_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: if (s_axi.arvalid && arready_q) begin
        r_idx_d   = IDX_W'((s_axi.araddr - BASE_ADDR) >> 2);
        r_err_d   = axi_decode(s_axi.araddr, s_axi.arsize, BASE_ADDR, SPAN);
        r_cnt_d   = r_load;
        arready_d = 1'b0;
        r_state_d = R_WAIT;
      end
      R_WAIT: if (r_cnt_q == '0) begin
        // Sampled before this edge's commit lands, so a same-word collision reads old data.
        rdata_d   = (r_err_q == AXI_RESP_OKAY) ? mem[r_idx_q] : 32'h0;
        rresp_d   = r_err_q;
        rvalid_d  = 1'b1;
        r_state_d = R_RESP;
      end else begin
        r_cnt_d = r_cnt_q - 5'd1;
      end
      R_RESP: if (s_axi.rready) begin
        rvalid_d  = 1'b0;
        arready_d = 1'b1;
        r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign aw_fire  = (w_state_q == W_IDLE) && s_axi.awvalid && awready_q;
  assign w_fire   = (w_state_q == W_IDLE) && s_axi.wvalid && wready_q;
  assign w_commit = (w_state_q == W_WAIT) && (w_cnt_q == '0) && (w_err_q == AXI_RESP_OKAY);

  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    w_idx_d   = w_idx_q;
    w_err_d   = w_err_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_fire) begin
          aw_got_d  = 1'b1;
          awready_d = 1'b0;
          w_idx_d   = IDX_W'((s_axi.awaddr - BASE_ADDR) >> 2);
          w_err_d   = axi_decode(s_axi.awaddr, s_axi.awsize, BASE_ADDR, SPAN);
        end
        if (w_fire) begin
          w_got_d  = 1'b1;
          wready_d = 1'b0;
          w_data_d = s_axi.wdata;
          w_strb_d = s_axi.wstrb;
        end
        if ((aw_got_q || aw_fire) && (w_got_q || w_fire)) begin
          w_cnt_d   = w_load;
          w_state_d = W_WAIT;
        end
      end
      W_WAIT: if (w_cnt_q == '0) begin
        bvalid_d  = 1'b1;
        bresp_d   = w_err_q;
        w_state_d = W_RESP;
      end else begin
        w_cnt_d = w_cnt_q - 5'd1;
      end
      W_RESP: if (s_axi.bready) begin
        bvalid_d  = 1'b0;
        aw_got_d  = 1'b0;
        w_got_d   = 1'b0;
        awready_d = 1'b1;
        wready_d  = 1'b1;
        w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      r_idx_q   <= '0;
      r_err_q   <= AXI_RESP_OKAY;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= AXI_RESP_OKAY;
      w_state_q <= W_IDLE;
      w_cnt_q   <= '0;
      w_idx_q   <= '0;
      w_err_q   <= AXI_RESP_OKAY;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= AXI_RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      r_idx_q   <= r_idx_d;
      r_err_q   <= r_err_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      w_idx_q   <= w_idx_d;
      w_err_q   <= w_err_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Array is deliberately left out of reset so committed data survives it.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_strb_q[i]) mem[w_idx_q][8*i +: 8] <= w_data_q[8*i +: 8];
      end
    end
  end

  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Scoreboard bench for axi_lite_sram_slave: drivers queue expected R/B beats, a forked monitor checks them.
module tb_axi_lite_sram_slave;
  import axi_lite_pkg::*;

  localparam int RL = 1;
  localparam int WL = 1;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_lite_sram_slave_if ifc ();

  axi_lite_sram_slave #(
    .BASE_ADDR(32'h0f000000), .MEM_WORDS(1024), .READ_LAT(RL), .WRITE_LAT(WL)
  ) dut (
    .clk(clk), .rst(rst), .s_axi(ifc.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  r_exp_t     rq[$];
  logic [1:0] bq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic monitor();
    r_exp_t     re;
    logic [1:0] be;
    forever begin
      @(negedge clk);
      if (!rst && ifc.rvalid && ifc.rready) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_unexpected actual rdata=%h rresp=%b required no beat", ifc.rdata, ifc.rresp);
        end else begin
          re = rq.pop_front();
          check("r_data", ifc.rdata, re.data);
          check("r_resp", {30'b0, ifc.rresp}, {30'b0, re.resp});
        end
      end
      if (!rst && ifc.bvalid && ifc.bready) begin
        if (bq.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected actual bresp=%b required no beat", ifc.bresp);
        end else begin
          be = bq.pop_front();
          check("b_resp", {30'b0, ifc.bresp}, {30'b0, be});
        end
      end
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_read(input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp, input int hold);
    r_exp_t e;
    int hs;
    bit seen;
    e.data = exp_data;
    e.resp = exp_resp;
    rq.push_back(e);
    ifc.rready  = (hold == 0);
    ifc.araddr  = addr;
    ifc.arsize  = size;
    ifc.arvalid = 1'b1;
    @(posedge clk); #1;
    hs = cyc;
    ifc.arvalid = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk); #1;
      if (ifc.rvalid) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL r_timeout addr=%h actual no rvalid required rvalid", addr);
      void'(rq.pop_back());
      ifc.rready = 1'b1;
      return;
    end
    check("r_latency", cyc - hs, 1 + RL);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_stable", {ifc.rvalid, ifc.arready, 30'b0} ^ ifc.rdata, {2'b10, 30'b0} ^ exp_data);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      ifc.rready = 1'b1;
    end
    seen = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk); #1;
      if (!ifc.rvalid) begin seen = 1'b1; break; end
    end
    check("r_done_arready", {30'b0, seen, ifc.arready}, 32'd3);
  endtask

  // mode 0: AW then W next cycle, 1: W then AW next cycle, 2: same cycle.
  task automatic do_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data,
                          input logic [3:0] strb, input int mode, input logic [1:0] exp_resp);
    int hs;
    bit seen;
    bq.push_back(exp_resp);
    ifc.awaddr = addr;
    ifc.awsize = size;
    ifc.wdata  = data;
    ifc.wstrb  = strb;
    case (mode)
      0: begin
        ifc.awvalid = 1'b1;
        @(posedge clk); #1;
        ifc.awvalid = 1'b0;
        check("aw_ready_drop", {30'b0, ifc.awready, ifc.wready}, 32'd1);
        ifc.wvalid = 1'b1;
        @(posedge clk); #1;
        ifc.wvalid = 1'b0;
      end
      1: begin
        ifc.wvalid = 1'b1;
        @(posedge clk); #1;
        ifc.wvalid = 1'b0;
        check("w_ready_drop", {30'b0, ifc.awready, ifc.wready}, 32'd2);
        ifc.awvalid = 1'b1;
        @(posedge clk); #1;
        ifc.awvalid = 1'b0;
      end
      default: begin
        ifc.awvalid = 1'b1;
        ifc.wvalid  = 1'b1;
        @(posedge clk); #1;
        ifc.awvalid = 1'b0;
        ifc.wvalid  = 1'b0;
      end
    endcase
    hs = cyc;
    seen = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (ifc.bvalid) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL b_timeout addr=%h actual no bvalid required bvalid", addr);
      void'(bq.pop_back());
      return;
    end
    check("b_latency", cyc - hs, 1 + WL);
    seen = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk); #1;
      if (!ifc.bvalid) begin seen = 1'b1; break; end
    end
    check("b_done_ready", {29'b0, seen, ifc.awready, ifc.wready}, 32'd7);
  endtask

  initial begin
    bit spurious;
    ifc.araddr = '0; ifc.arsize = '0; ifc.arvalid = 1'b0; ifc.rready = 1'b1;
    ifc.awaddr = '0; ifc.awsize = '0; ifc.awvalid = 1'b0;
    ifc.wdata = '0; ifc.wstrb = '0; ifc.wvalid = 1'b0; ifc.bready = 1'b1;
    rst = 1'b1;
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", {29'b0, ifc.arready, ifc.awready, ifc.wready}, 32'd7);
    check("reset_valid", {30'b0, ifc.rvalid, ifc.bvalid}, 32'd0);
    check("reset_rdata", ifc.rdata, 32'd0);
    check("reset_resp", {28'b0, ifc.rresp, ifc.bresp}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    do_write(32'h0f000010, AXI_SIZE_W, 32'hdeadbeef, 4'hf, 0, AXI_RESP_OKAY);
    do_read (32'h0f000010, AXI_SIZE_W, 32'hdeadbeef, AXI_RESP_OKAY, 0);
    do_write(32'h0f000010, AXI_SIZE_W, 32'h00ab0000, 4'b0100, 0, AXI_RESP_OKAY);
    do_read (32'h0f000010, AXI_SIZE_W, 32'hdeabbeef, AXI_RESP_OKAY, 0);
    do_read (32'h0f000013, AXI_SIZE_B, 32'hdeabbeef, AXI_RESP_OKAY, 0);
    do_read (32'h10000000, AXI_SIZE_W, 32'h0, AXI_RESP_DECERR, 0);
    do_write(32'h0f000000, AXI_SIZE_W, 32'h11223344, 4'hf, 0, AXI_RESP_OKAY);
    do_write(32'h0f000000, 3'b011, 32'hffffffff, 4'hf, 0, AXI_RESP_SLVERR);
    do_read (32'h0f000000, AXI_SIZE_W, 32'h11223344, AXI_RESP_OKAY, 0);
    do_read (32'h0f000000, 3'b011, 32'h0, AXI_RESP_SLVERR, 0);
    do_write(32'h0f000ffc, AXI_SIZE_W, 32'ha5a55a5a, 4'hf, 2, AXI_RESP_OKAY);
    do_read (32'h0f000ffc, AXI_SIZE_W, 32'ha5a55a5a, AXI_RESP_OKAY, 0);
    do_read (32'h0f001000, AXI_SIZE_W, 32'h0, AXI_RESP_DECERR, 0);
    do_read (32'h0efffffc, AXI_SIZE_W, 32'h0, AXI_RESP_DECERR, 0);
    do_write(32'h0f001000, AXI_SIZE_W, 32'h12345678, 4'hf, 0, AXI_RESP_DECERR);
    do_write(32'h0f000020, AXI_SIZE_W, 32'hcafef00d, 4'hf, 1, AXI_RESP_OKAY);
    do_read (32'h0f000020, AXI_SIZE_W, 32'hcafef00d, AXI_RESP_OKAY, 0);
    do_write(32'h0f000020, AXI_SIZE_W, 32'hffffffff, 4'h0, 2, AXI_RESP_OKAY);
    do_read (32'h0f000020, AXI_SIZE_W, 32'hcafef00d, AXI_RESP_OKAY, 0);
    do_read (32'h0f000010, AXI_SIZE_W, 32'hdeabbeef, AXI_RESP_OKAY, 5);

    // Reset while the read is still counting down.
    ifc.araddr  = 32'h0f000010;
    ifc.arsize  = AXI_SIZE_W;
    ifc.arvalid = 1'b1;
    @(posedge clk); #1;
    ifc.arvalid = 1'b0;
    check("rst_mid_busy", {31'b0, ifc.arready}, 32'd0);
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", {30'b0, ifc.rvalid, ifc.arready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    spurious = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (ifc.rvalid) spurious = 1'b1;
    end
    check("rst_no_spurious", {31'b0, spurious}, 32'd0);
    @(posedge clk); #1;
    do_read (32'h0f000010, AXI_SIZE_W, 32'hdeabbeef, AXI_RESP_OKAY, 0);

    repeat (3) @(posedge clk);
    check("r_queue_empty", rq.size(), 32'd0);
    check("b_queue_empty", bq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
